// File: rtl/hdlc_rx_deframer_if.sv
// Bus between the HDLC receive deframer and the Rx frame buffer/control stage.
// The master side is the deframer: it takes the serial line and drives the
// decoded strobes and data.
interface hdlc_rx_deframer_if;
  logic       Rx;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte;
  logic       Rx_FlagDetect;
  logic       Rx_AbortDetect;
  logic       Rx_IdleDetect;
  logic       Rx_ValidFrame;
  logic       Rx_EoF;
  logic       Rx_FrameError;

  modport master (
    input  Rx,
    output Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect,
           Rx_IdleDetect, Rx_ValidFrame, Rx_EoF, Rx_FrameError
  );

  modport slave (
    output Rx,
    input  Rx_Data, Rx_NewByte, Rx_FlagDetect, Rx_AbortDetect,
           Rx_IdleDetect, Rx_ValidFrame, Rx_EoF, Rx_FrameError
  );
endinterface

// File: rtl/hdlc_rx_deframer.sv
// Bit-level HDLC receive front end: flag/abort/idle detection, zero
// destuffing, an 8-bit delay line that keeps closing-flag bits out of the
// payload, and LSB-first byte assembly with end-of-frame qualification.
module hdlc_rx_deframer #(
  parameter int unsigned MIN_BYTES = 1
) (
  input logic Clk,
  input logic Rst,
  hdlc_rx_deframer_if.master rxIf
);

  typedef enum logic [1:0] {HUNT, SYNC, FRAME} stateT;

  stateT      state;
  stateT      stateNext;

  logic       rxD;
  // Only the seven older raw bits are stored; the newest is rxD itself.
  logic [6:0] rawHist;
  logic [7:0] rawWin;
  logic       isFlag, isAbort, isIdle;
  logic [2:0] onesCnt;
  logic       stuffed, dataIn;
  logic [7:0] dly;
  logic [3:0] dlyCnt;
  logic       exitValid, exitBit;
  logic [2:0] bitCnt, endBits;
  logic [7:0] byteCnt, endBytes;
  logic       endErr;
  logic [7:0] asmReg, asmNext;
  logic       take, flush, clearCnt, fall, frameErr, byteDone;
  logic       eofPend, errPend;

  logic [7:0] rxData;
  logic       newByte, flagDet, abortDet, idleDet, validFrame, eof, frameError;

  // Window in arrival order: rawWin[7] is the oldest bit, rawWin[0] the newest.
  assign rawWin  = {rawHist, rxD};
  assign isFlag  = (rawWin == 8'h7E);
  assign isAbort = (rawWin == 8'h7F);
  assign isIdle  = (rawWin == 8'hFF);

  assign stuffed   = !rxD && (onesCnt == 3'd5) && (state != HUNT);
  assign dataIn    = (state != HUNT) && !stuffed;
  assign exitValid = dataIn && (dlyCnt == 4'd8);
  assign exitBit   = dly[7];
  assign byteDone  = take && (bitCnt == 3'd7);

  // Bit/byte totals as they stand once the current exiting bit is counted.
  assign endBits  = bitCnt + {2'b00, exitValid};
  assign endBytes = (exitValid && (bitCnt == 3'd7) && (byteCnt != 8'hFF)) ?
                    byteCnt + 8'd1 : byteCnt;
  assign endErr   = (endBits != 3'd0) || (32'(endBytes) < MIN_BYTES);

  // Byte being assembled with the exiting bit dropped into its slot.
  always_comb begin
    asmNext         = asmReg;
    asmNext[bitCnt] = exitBit;
  end

  // Next-state and per-edge control decisions.
  always_comb begin
    stateNext = state;
    flush     = 1'b0;
    take      = 1'b0;
    clearCnt  = 1'b0;
    fall      = 1'b0;
    frameErr  = 1'b0;
    case (state)
      HUNT: begin
        clearCnt = 1'b1;
        if (isFlag) begin
          stateNext = SYNC;
          flush     = 1'b1;
        end
      end
      SYNC: begin
        if (isFlag) begin
          flush = 1'b1;
        end else if (isAbort) begin
          stateNext = HUNT;
        end else if (exitValid) begin
          stateNext = FRAME;
          take      = 1'b1;
        end
      end
      FRAME: begin
        if (isFlag) begin
          // The last payload bit leaves the delay line on the flag's own edge,
          // so it is still assembled before the frame is closed.
          stateNext = SYNC;
          flush     = 1'b1;
          take      = exitValid;
          fall      = 1'b1;
          clearCnt  = 1'b1;
          frameErr  = endErr;
        end else if (isAbort) begin
          stateNext = HUNT;
          fall      = 1'b1;
          clearCnt  = 1'b1;
        end else begin
          take = exitValid;
        end
      end
      default: begin
        stateNext = HUNT;
        clearCnt  = 1'b1;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state <= HUNT;
    else     state <= stateNext;
  end

  // Line sampling, delay line, byte assembly and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rxD        <= 1'b0;
      rawHist    <= '0;
      onesCnt    <= '0;
      dly        <= '0;
      dlyCnt     <= '0;
      bitCnt     <= '0;
      byteCnt    <= '0;
      asmReg     <= '0;
      eofPend    <= 1'b0;
      errPend    <= 1'b0;
      rxData     <= '0;
      newByte    <= 1'b0;
      flagDet    <= 1'b0;
      abortDet   <= 1'b0;
      idleDet    <= 1'b0;
      validFrame <= 1'b0;
      eof        <= 1'b0;
      frameError <= 1'b0;
    end else begin
      rxD     <= rxIf.Rx;
      rawHist <= rawWin[6:0];
      onesCnt <= rxD ? ((onesCnt == 3'd7) ? 3'd7 : onesCnt + 3'd1) : '0;

      if (dataIn) dly <= {dly[6:0], rxD};
      if (flush)                            dlyCnt <= '0;
      else if (dataIn && dlyCnt != 4'd8)    dlyCnt <= dlyCnt + 4'd1;

      if (clearCnt) begin
        bitCnt  <= '0;
        byteCnt <= '0;
      end else if (take) begin
        bitCnt  <= bitCnt + 3'd1;
        byteCnt <= endBytes;
      end
      if (take) asmReg <= asmNext;

      newByte <= byteDone;
      if (byteDone) rxData <= asmNext;

      flagDet    <= isFlag;
      abortDet   <= isAbort;
      idleDet    <= isIdle;
      validFrame <= (stateNext == FRAME);
      eofPend    <= fall;
      errPend    <= fall && frameErr;
      eof        <= eofPend;
      frameError <= errPend;
    end
  end

  assign rxIf.Rx_Data        = rxData;
  assign rxIf.Rx_NewByte     = newByte;
  assign rxIf.Rx_FlagDetect  = flagDet;
  assign rxIf.Rx_AbortDetect = abortDet;
  assign rxIf.Rx_IdleDetect  = idleDet;
  assign rxIf.Rx_ValidFrame  = validFrame;
  assign rxIf.Rx_EoF         = eof;
  assign rxIf.Rx_FrameError  = frameError;

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Testbench for hdlc_rx_deframer: directed scenarios plus a random stream of
// stuffed frames checked against payload-level expectations.
module tb_hdlc_rx_deframer;

  localparam int MIN_B = 1;

  logic Clk;
  logic Rst;
  hdlc_rx_deframer_if busIf ();

  hdlc_rx_deframer #(.MIN_BYTES(MIN_B)) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .rxIf (busIf)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int posCnt = 0;
  always @(posedge Clk) posCnt <= posCnt + 1;

  int checks = 0;
  int errors = 0;

  // Event logs, stamped with the rising-edge count current at each sample.
  int         flagT[$];
  int         abortT[$];
  int         fallT[$];
  int         eofT[$];
  int         idleT[$];
  logic [7:0] byteQ[$];
  bit         eofErr[$];
  int         orphanEof = 0;
  int         validCnt = 0;
  logic       prevValid = 1'b0;
  logic       fellLast = 1'b0;

  // Output monitor on the falling edge.
  always @(negedge Clk) begin
    if (busIf.Rx_FlagDetect)  flagT.push_back(posCnt);
    if (busIf.Rx_AbortDetect) abortT.push_back(posCnt);
    if (busIf.Rx_IdleDetect)  idleT.push_back(posCnt);
    if (busIf.Rx_NewByte)     byteQ.push_back(busIf.Rx_Data);
    if (prevValid && !busIf.Rx_ValidFrame) fallT.push_back(posCnt);
    if (busIf.Rx_EoF) begin
      eofT.push_back(posCnt);
      eofErr.push_back(busIf.Rx_FrameError);
      if (!fellLast) orphanEof <= orphanEof + 1;
    end
    if (busIf.Rx_ValidFrame) validCnt <= validCnt + 1;
    fellLast  <= prevValid && !busIf.Rx_ValidFrame;
    prevValid <= busIf.Rx_ValidFrame;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int fb, ab, bb, eb, lb, ib, vb;
  int lastStamp;
  bit payload[$];

  function automatic int flagAt(int i);  return (i < flagT.size())  ? flagT[i]  : -1; endfunction
  function automatic int abortAt(int i); return (i < abortT.size()) ? abortT[i] : -1; endfunction
  function automatic int fallAt(int i);  return (i < fallT.size())  ? fallT[i]  : -1; endfunction
  function automatic int eofAt(int i);   return (i < eofT.size())   ? eofT[i]   : -1; endfunction
  function automatic int idleAt(int i);  return (i < idleT.size())  ? idleT[i]  : -1; endfunction
  function automatic int errAt(int i);   return (i < eofErr.size()) ? int'(eofErr[i]) : -1; endfunction
  function automatic int byteAt(int i);  return (i < byteQ.size())  ? int'(byteQ[i]) : -1; endfunction

  function automatic logic [14:0] outBus();
    return {busIf.Rx_Data, busIf.Rx_NewByte, busIf.Rx_FlagDetect, busIf.Rx_AbortDetect,
            busIf.Rx_IdleDetect, busIf.Rx_ValidFrame, busIf.Rx_EoF, busIf.Rx_FrameError};
  endfunction

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic mark();
    fb = flagT.size();
    ab = abortT.size();
    bb = byteQ.size();
    eb = eofT.size();
    lb = fallT.size();
    ib = idleT.size();
    vb = validCnt;
  endtask

  task automatic sendBit(input logic b);
    busIf.Rx  = b;
    lastStamp = posCnt;
    @(posedge Clk);
    #1;
  endtask

  task automatic doReset();
    Rst      = 1'b1;
    busIf.Rx = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outputs", int'(outBus()), 0);
    Rst = 1'b0;
  endtask

  task automatic sendFlag();
    for (int i = 0; i < 8; i++) sendBit((i != 0) && (i != 7));
  endtask

  task automatic sendAbort();
    sendBit(1'b0);
    repeat (7) sendBit(1'b1);
  endtask

  task automatic sendOnes(input int n);
    repeat (n) sendBit(1'b1);
  endtask

  task automatic pushByte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) payload.push_back(v[i]);
  endtask

  // Transmitter-side stuffing: a 0 follows every run of five 1s.
  task automatic sendPayload();
    int ones;
    ones = 0;
    foreach (payload[i]) begin
      sendBit(payload[i]);
      if (payload[i]) begin
        ones++;
        if (ones == 5) begin
          sendBit(1'b0);
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
    payload.delete();
  endtask

  logic [7:0] expBytes[$];
  bit         expErr[$];
  int         s1, s2, sa, s8;

  initial begin
    Rst      = 1'b1;
    busIf.Rx = 1'b0;

    // Single good frame carrying 0xA5.
    doReset();
    mark();
    sendFlag();
    s1 = lastStamp;
    pushByte(8'hA5);
    sendPayload();
    sendFlag();
    s2 = lastStamp;
    sendOnes(5);
    check("s1_flag_count", flagT.size() - fb, 2);
    check("s1_flag0_time", flagAt(fb), s1 + 2);
    check("s1_flag1_time", flagAt(fb + 1), s2 + 2);
    check("s1_byte_count", byteQ.size() - bb, 1);
    check("s1_byte", byteAt(bb), 'hA5);
    check("s1_fall_time", fallAt(lb), s2 + 2);
    check("s1_eof_time", eofAt(eb), s2 + 3);
    check("s1_eof_err", errAt(eb), 0);

    // 0xFF needs one stuffed zero.
    doReset();
    mark();
    sendFlag();
    pushByte(8'hFF);
    sendPayload();
    sendFlag();
    sendOnes(5);
    check("s2_byte_count", byteQ.size() - bb, 1);
    check("s2_byte", byteAt(bb), 'hFF);
    check("s2_abort_count", abortT.size() - ab, 0);
    check("s2_eof_count", eofT.size() - eb, 1);
    check("s2_eof_err", errAt(eb), 0);

    // Abort inside a frame, then a lone byte while hunting.
    doReset();
    mark();
    sendFlag();
    pushByte(8'h5A);
    payload.push_back(1'b1);
    payload.push_back(1'b0);
    payload.push_back(1'b1);
    sendPayload();
    sendAbort();
    sa = lastStamp;
    sendOnes(4);
    check("s3_byte_count", byteQ.size() - bb, 1);
    check("s3_byte", byteAt(bb), 'h5A);
    check("s3_abort_count", abortT.size() - ab, 1);
    check("s3_abort_time", abortAt(ab), sa + 2);
    check("s3_fall_time", fallAt(lb), sa + 2);
    check("s3_eof_time", eofAt(eb), sa + 3);
    check("s3_eof_err", errAt(eb), 0);
    mark();
    for (int i = 0; i < 8; i++) sendBit(i >= 2 && i <= 5);
    repeat (10) sendBit(1'b0);
    check("s3_hunt_bytes", byteQ.size() - bb, 0);
    check("s3_hunt_valid", validCnt - vb, 0);

    // Misaligned frame of 12 data bits.
    doReset();
    mark();
    sendFlag();
    pushByte(8'h3C);
    payload.push_back(1'b1);
    payload.push_back(1'b0);
    payload.push_back(1'b0);
    payload.push_back(1'b1);
    sendPayload();
    sendFlag();
    sendOnes(5);
    check("s4_byte_count", byteQ.size() - bb, 1);
    check("s4_byte", byteAt(bb), 'h3C);
    check("s4_eof_count", eofT.size() - eb, 1);
    check("s4_eof_err", errAt(eb), 1);

    // Two frames sharing a flag.
    doReset();
    mark();
    sendFlag();
    pushByte(8'h12);
    sendPayload();
    sendFlag();
    pushByte(8'h34);
    sendPayload();
    sendFlag();
    sendOnes(5);
    check("s5_byte_count", byteQ.size() - bb, 2);
    check("s5_byte0", byteAt(bb), 'h12);
    check("s5_byte1", byteAt(bb + 1), 'h34);
    check("s5_eof_count", eofT.size() - eb, 2);
    check("s5_eof_err0", errAt(eb), 0);
    check("s5_eof_err1", errAt(eb + 1), 0);

    // Idle line from reset.
    doReset();
    mark();
    s8 = 0;
    for (int i = 1; i <= 16; i++) begin
      sendBit(1'b1);
      if (i == 8) s8 = lastStamp;
    end
    repeat (3) sendBit(1'b0);
    check("s6_idle_count", idleT.size() - ib, 9);
    check("s6_idle_first", idleAt(ib), s8 + 2);
    check("s6_flag_count", flagT.size() - fb, 0);
    check("s6_valid", validCnt - vb, 0);

    // Reset in the middle of a frame.
    doReset();
    mark();
    sendFlag();
    pushByte(8'hA5);
    sendPayload();
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    check("s7_valid_before", int'(busIf.Rx_ValidFrame), 1);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    check("s7_outputs_after_rst", int'(outBus()), 0);
    Rst = 1'b0;
    mark();
    sendOnes(6);
    check("s7_no_eof", eofT.size() - eb, 0);

    // Random stream of stuffed frames separated by shared flags.
    doReset();
    mark();
    expBytes.delete();
    expErr.delete();
    sendFlag();
    for (int f = 0; f < 12; f++) begin
      int n;
      n = ($urandom_range(0, 1) == 1) ? 8 * int'($urandom_range(1, 4)) : int'($urandom_range(2, 33));
      for (int i = 0; i < n; i++) payload.push_back(1'($urandom_range(0, 1)));
      for (int k = 0; k < n / 8; k++) begin
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = payload[8 * k + j];
        expBytes.push_back(b);
      end
      expErr.push_back((n % 8 != 0) || (n / 8 < MIN_B));
      sendPayload();
      sendFlag();
    end
    sendOnes(5);
    check("rnd_byte_count", byteQ.size() - bb, expBytes.size());
    for (int i = 0; i < expBytes.size(); i++)
      check($sformatf("rnd_byte%0d", i), byteAt(bb + i), int'(expBytes[i]));
    check("rnd_eof_count", eofT.size() - eb, expErr.size());
    for (int i = 0; i < expErr.size(); i++) begin
      check($sformatf("rnd_err%0d", i), errAt(eb + i), int'(expErr[i]));
      check($sformatf("rnd_eof_after_fall%0d", i), eofAt(eb + i), fallAt(lb + i) + 1);
    end

    check("orphan_eof", orphanEof, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
